// File: rtl/frankie_pkg.sv
// Shared encodings for the Frankie control sequencer: states, opcodes, ALU codes,
// opcode classes and the opcode -> ALU operation mapping.
package frankie_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_ONE, CLS_RD, CLS_WR, CLS_HALT, CLS_ILL
  } op_class_e;

  localparam logic [4:0] APUT = 5'b00000;
  localparam logic [4:0] SPUT = 5'b00001;
  localparam logic [4:0] AADD = 5'b00010;
  localparam logic [4:0] ASUB = 5'b00011;
  localparam logic [4:0] SPEK = 5'b00100;
  localparam logic [4:0] SPOP = 5'b00101;
  localparam logic [4:0] RPOP = 5'b00110;
  localparam logic [4:0] JIMM = 5'b00111;
  localparam logic [4:0] JACC = 5'b01000;
  localparam logic [4:0] JCMP = 5'b01001;
  localparam logic [4:0] JRET = 5'b01010;
  localparam logic [4:0] JFNC = 5'b01011;
  localparam logic [4:0] CEQU = 5'b01100;
  localparam logic [4:0] CLES = 5'b01101;
  localparam logic [4:0] CGRE = 5'b01110;
  localparam logic [4:0] LORR = 5'b01111;
  localparam logic [4:0] LAND = 5'b10000;
  localparam logic [4:0] SHFL = 5'b10001;
  localparam logic [4:0] SHFR = 5'b10010;
  localparam logic [4:0] LOAD = 5'b10011;
  localparam logic [4:0] STOR = 5'b10100;
  localparam logic [4:0] BKAC = 5'b10101;
  localparam logic [4:0] BKRA = 5'b10110;
  localparam logic [4:0] SWAP = 5'b10111;
  localparam logic [4:0] HALT_OP_DEFAULT = 5'b11111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_LT  = 4'b0100;
  localparam logic [3:0] ALU_GT  = 4'b0101;
  localparam logic [3:0] ALU_EQ  = 4'b0110;
  localparam logic [3:0] ALU_SHL = 4'b1000;
  localparam logic [3:0] ALU_SHR = 4'b1001;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      AADD:    return ALU_ADD;
      ASUB:    return ALU_SUB;
      CEQU:    return ALU_EQ;
      CLES:    return ALU_LT;
      CGRE:    return ALU_GT;
      LORR:    return ALU_OR;
      SHFL:    return ALU_SHL;
      SHFR:    return ALU_SHR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/frankie_op_classify.sv
// Combinational opcode classifier: maps the IR opcode to its execution class
// and flags undefined opcodes.
module frankie_op_classify
  import frankie_pkg::*;
#(
  parameter int                  OPCODE_W = 5,
  parameter logic [OPCODE_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class,
  output logic                illegal
);

  always_comb begin
    op_class = CLS_ILL;
    if (opcode == HALT_OP) begin
      op_class = CLS_HALT;
    end else begin
      case (opcode)
        AADD, ASUB, CEQU, CLES, CGRE, LORR, LAND, SHFL, SHFR: op_class = CLS_ALU;
        APUT, JIMM, JACC, JCMP, JRET, JFNC, SWAP:             op_class = CLS_ONE;
        SPEK, SPOP, RPOP, LOAD:                               op_class = CLS_RD;
        SPUT, STOR, BKAC, BKRA:                               op_class = CLS_WR;
        default:                                              op_class = CLS_ILL;
      endcase
    end
  end

  assign illegal = (op_class == CLS_ILL);

endmodule

// File: rtl/frankie_seq_ctrl.sv
// Frankie multicycle control sequencer with req/ack memory handshake, HALT and
// illegal-opcode detection. Define MEM_TIMEOUT_EN to add the memory-ack timeout.
module frankie_seq_ctrl
  import frankie_pkg::*;
#(
  parameter int                  OPCODE_W   = 5,
  parameter int                  ALUOP_W    = 4,
  parameter logic [OPCODE_W-1:0] HALT_OP    = HALT_OP_DEFAULT,
  parameter int                  TMO_CYCLES = 64
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] OPCODE,
  input  logic                flagbit,
  input  logic                mem_ack,
  input  logic                resume,
  output logic                mem_req,
  output logic                MemWrite,
  output logic [2:0]          MemDst,
  output logic [1:0]          MemSrc,
  output logic                InstWrite,
  output logic                PCWrite,
  output logic                SPWrite,
  output logic                MaryWrite,
  output logic                ShelleyWrite,
  output logic                CompWrite,
  output logic                RAWrite,
  output logic [2:0]          PCSrc,
  output logic [1:0]          SPSrc,
  output logic [1:0]          MarySrc,
  output logic [1:0]          ShelleySrc,
  output logic                RASrc,
  output logic                SrcA,
  output logic [1:0]          SrcB,
  output logic [ALUOP_W-1:0]  ALUOP,
  output logic [2:0]          state_o,
  output logic                halted,
  output logic                illegal,
  output logic                tmo_err
);

  state_e    state, state_nxt;
  op_class_e cls;
  logic      is_ill;
  // Cleared asynchronously by Reset, so every output drops at once and stays
  // low for the first cycle after release.
  logic      run;

  frankie_op_classify #(.OPCODE_W(OPCODE_W), .HALT_OP(HALT_OP)) u_classify (
    .opcode   (OPCODE),
    .op_class (cls),
    .illegal  (is_ill)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_q, waiting, tmo_hit;

  assign waiting = run && (state == S_FETCH || state == S_MEM) && !mem_ack;
  assign tmo_hit = waiting && (tmo_cnt == TMO_W'(TMO_CYCLES - 1));
  assign tmo_err = tmo_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      if (state_nxt != state) tmo_cnt <= '0;
      else if (waiting)       tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TMO_CYCLES;
  assign tmo_err    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (run) begin
      case (state)
        S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
        S_DECODE: begin
          case (cls)
            CLS_ALU, CLS_ONE: state_nxt = S_EXEC;
            CLS_RD, CLS_WR:   state_nxt = S_MEM;
            CLS_HALT:         state_nxt = S_HALT;
            default:          state_nxt = S_FETCH;
          endcase
        end
        S_EXEC:   state_nxt = (cls == CLS_ALU) ? S_WB : S_FETCH;
        S_MEM:    if (mem_ack) state_nxt = (cls == CLS_RD) ? S_WB : S_FETCH;
        S_WB:     state_nxt = S_FETCH;
        S_HALT:   if (resume) state_nxt = S_FETCH;
        default:  state_nxt = S_FETCH;
      endcase
    end
`ifdef MEM_TIMEOUT_EN
    if (tmo_hit) state_nxt = S_HALT;
`endif
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= S_FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  assign state_o = state;

  always_comb begin
    mem_req = 1'b0; MemWrite = 1'b0; MemDst = '0; MemSrc = '0;
    InstWrite = 1'b0; PCWrite = 1'b0; SPWrite = 1'b0; MaryWrite = 1'b0;
    ShelleyWrite = 1'b0; CompWrite = 1'b0; RAWrite = 1'b0;
    PCSrc = '0; SPSrc = '0; MarySrc = '0; ShelleySrc = '0;
    RASrc = 1'b0; SrcA = 1'b0; SrcB = '0; ALUOP = '0;
    halted = 1'b0; illegal = 1'b0;
    if (run) begin
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            InstWrite = 1'b1;
            PCWrite   = 1'b1;
          end
        end
        S_DECODE: illegal = is_ill;
        S_EXEC: begin
          if (cls == CLS_ALU) begin
            SrcB  = flagbit ? 2'b00 : 2'b01;
            ALUOP = ALUOP_W'(alu_code(OPCODE));
          end else begin
            case (OPCODE)
              JIMM: begin PCWrite = 1'b1; PCSrc = flagbit ? 3'b001 : 3'b010; end
              JACC: begin PCWrite = 1'b1; PCSrc = flagbit ? 3'b101 : 3'b100; end
              JCMP: begin PCWrite = 1'b1; PCSrc = flagbit ? 3'b111 : 3'b110; end
              JRET: begin PCWrite = 1'b1; PCSrc = 3'b011; end
              JFNC: begin
                PCWrite = 1'b1; PCSrc = flagbit ? 3'b001 : 3'b010;
                RAWrite = 1'b1; RASrc = 1'b1;
              end
              APUT: begin
                if (flagbit) begin ShelleyWrite = 1'b1; ShelleySrc = 2'b01; end
                else         begin MaryWrite = 1'b1;    MarySrc = 2'b11;    end
              end
              SWAP: begin
                MaryWrite = 1'b1; MarySrc = 2'b10;
                ShelleyWrite = 1'b1; ShelleySrc = 2'b10;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          if (OPCODE == SPEK)                 MemDst = 3'b101;
          else if (OPCODE inside {LOAD, STOR}) MemDst = flagbit ? 3'b011 : 3'b001;
          else                                 MemDst = 3'b100;
          if (cls == CLS_WR) begin
            MemWrite = 1'b1;
            if (OPCODE == BKAC)      MemSrc = {1'b0, flagbit};
            else if (OPCODE == BKRA) MemSrc = 2'b10;
            if (mem_ack && OPCODE inside {SPUT, BKAC, BKRA}) begin
              SPWrite = 1'b1; SPSrc = 2'b01;
            end
          end
        end
        S_WB: begin
          if (cls == CLS_ALU) begin
            if (OPCODE inside {CEQU, CLES, CGRE}) CompWrite = 1'b1;
            else begin MaryWrite = 1'b1; MarySrc = 2'b01; end
          end else begin
            if (OPCODE == RPOP)                RAWrite = 1'b1;
            else if (OPCODE == SPEK && flagbit) ShelleyWrite = 1'b1;
            else                               MaryWrite = 1'b1;
            if (OPCODE inside {SPOP, RPOP}) begin SPWrite = 1'b1; SPSrc = 2'b10; end
          end
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frankie_seq_ctrl.sv
// Scoreboard bench for frankie_seq_ctrl: each scenario queues per-cycle stimulus
// with the expected output vector, then pops and compares at the falling edge.
module tb_frankie_seq_ctrl;

  logic       CLK = 1'b0, Reset = 1'b1;
  logic [4:0] OPCODE = '0;
  logic       flagbit = 1'b0, mem_ack = 1'b0, resume = 1'b0;
  logic       mem_req, MemWrite, InstWrite, PCWrite, SPWrite, MaryWrite, ShelleyWrite;
  logic       CompWrite, RAWrite, RASrc, SrcA, halted, illegal, tmo_err;
  logic [2:0] MemDst, PCSrc, state_o;
  logic [1:0] MemSrc, SPSrc, MarySrc, ShelleySrc, SrcB;
  logic [3:0] ALUOP;

  int checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  frankie_seq_ctrl #(.TMO_CYCLES(4)) dut (
    .CLK(CLK), .Reset(Reset), .OPCODE(OPCODE), .flagbit(flagbit), .mem_ack(mem_ack),
    .resume(resume), .mem_req(mem_req), .MemWrite(MemWrite), .MemDst(MemDst),
    .MemSrc(MemSrc), .InstWrite(InstWrite), .PCWrite(PCWrite), .SPWrite(SPWrite),
    .MaryWrite(MaryWrite), .ShelleyWrite(ShelleyWrite), .CompWrite(CompWrite),
    .RAWrite(RAWrite), .PCSrc(PCSrc), .SPSrc(SPSrc), .MarySrc(MarySrc),
    .ShelleySrc(ShelleySrc), .RASrc(RASrc), .SrcA(SrcA), .SrcB(SrcB), .ALUOP(ALUOP),
    .state_o(state_o), .halted(halted), .illegal(illegal), .tmo_err(tmo_err)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, mw;
    logic [2:0] mdst;
    logic [1:0] msrc;
    logic       iw, pcw, spw, maw, shw, cw, raw;
    logic [2:0] pcsrc;
    logic [1:0] spsrc, masrc, shsrc;
    logic       rasrc, srca;
    logic [1:0] srcb;
    logic [3:0] aluop;
    logic       halt, ill, tmo;
  } ctl_t;

  typedef struct {
    logic [4:0] op;
    logic       fl, ack, res;
    ctl_t       e;
  } step_t;

  step_t sq[$];

  function automatic ctl_t actual();
    ctl_t c;
    c.st = state_o; c.req = mem_req; c.mw = MemWrite; c.mdst = MemDst; c.msrc = MemSrc;
    c.iw = InstWrite; c.pcw = PCWrite; c.spw = SPWrite; c.maw = MaryWrite;
    c.shw = ShelleyWrite; c.cw = CompWrite; c.raw = RAWrite; c.pcsrc = PCSrc;
    c.spsrc = SPSrc; c.masrc = MarySrc; c.shsrc = ShelleySrc; c.rasrc = RASrc;
    c.srca = SrcA; c.srcb = SrcB; c.aluop = ALUOP; c.halt = halted; c.ill = illegal;
    c.tmo = tmo_err;
    return c;
  endfunction

  function automatic ctl_t st_only(input logic [2:0] s);
    ctl_t c = '0;
    c.st = s;
    return c;
  endfunction

  function automatic ctl_t fetch_exp(input logic ack);
    ctl_t c = st_only(3'd0);
    c.req = 1'b1; c.iw = ack; c.pcw = ack;
    return c;
  endfunction

  function automatic void push(input logic [4:0] op, input logic fl, input logic ack,
                               input logic res, input ctl_t e);
    step_t s;
    s.op = op; s.fl = fl; s.ack = ack; s.res = res; s.e = e;
    sq.push_back(s);
  endfunction

  task automatic test_reset();
    step_t s; ctl_t a; int n = 0;
    #1;
    a = actual(); checks++;
    if (a !== ctl_t'('0)) begin failures++; $display("FAIL reset_hold got=%h exp=%h", a, ctl_t'('0)); end
    @(posedge CLK); #1; Reset = 1'b0;
    push(5'b00000, 1'b0, 1'b0, 1'b0, st_only(3'd0));
    push(5'b00000, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0));
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_aadd();
    step_t s; ctl_t a, c; int n = 0;
    push(5'b00010, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b00010, 1'b0, 1'b1, 1'b0, st_only(3'd1));
    c = st_only(3'd2); c.srcb = 2'b01; c.aluop = 4'b0010;
    push(5'b00010, 1'b0, 1'b1, 1'b0, c);
    c = st_only(3'd4); c.maw = 1'b1; c.masrc = 2'b01;
    push(5'b00010, 1'b0, 1'b1, 1'b0, c);
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL aadd cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_load_wait();
    step_t s; ctl_t a, c; int n = 0;
    push(5'b10011, 1'b1, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b10011, 1'b1, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mdst = 3'b011;
    for (int i = 0; i < 4; i++) push(5'b10011, 1'b1, (i == 3), 1'b0, c);
    c = st_only(3'd4); c.maw = 1'b1;
    push(5'b10011, 1'b1, 1'b0, 1'b0, c);
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL load_at_wait cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_bkra();
    step_t s; ctl_t a, c; int n = 0;
    push(5'b10110, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b10110, 1'b0, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mw = 1'b1; c.mdst = 3'b100; c.msrc = 2'b10;
    c.spw = 1'b1; c.spsrc = 2'b01;
    push(5'b10110, 1'b0, 1'b1, 1'b0, c);
    push(5'b10110, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0));
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL bkra cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_illegal_halt();
    step_t s; ctl_t a, c; int n = 0;
    push(5'b11010, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    c = st_only(3'd1); c.ill = 1'b1;
    push(5'b11010, 1'b0, 1'b0, 1'b0, c);
    push(5'b11010, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0));
    push(5'b11111, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b11111, 1'b0, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd5); c.halt = 1'b1;
    push(5'b11111, 1'b0, 1'b1, 1'b0, c);
    push(5'b11111, 1'b0, 1'b0, 1'b0, c);
    push(5'b11111, 1'b0, 1'b0, 1'b1, c);
    push(5'b11111, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0));
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL illegal_halt cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_misc_ops();
    step_t s; ctl_t a, c; int n = 0;
    // CGRE@: compare with SrcB=00, result to Comp
    push(5'b01110, 1'b1, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b01110, 1'b1, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd2); c.aluop = 4'b0101; push(5'b01110, 1'b1, 1'b0, 1'b0, c);
    c = st_only(3'd4); c.cw = 1'b1;       push(5'b01110, 1'b1, 1'b0, 1'b0, c);
    // JFNC
    push(5'b01011, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b01011, 1'b0, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd2); c.pcw = 1'b1; c.pcsrc = 3'b010; c.raw = 1'b1; c.rasrc = 1'b1;
    push(5'b01011, 1'b0, 1'b0, 1'b0, c);
    // APUT@
    push(5'b00000, 1'b1, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b00000, 1'b1, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd2); c.shw = 1'b1; c.shsrc = 2'b01; push(5'b00000, 1'b1, 1'b0, 1'b0, c);
    // SPOP
    push(5'b00101, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b00101, 1'b0, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mdst = 3'b100; push(5'b00101, 1'b0, 1'b1, 1'b0, c);
    c = st_only(3'd4); c.maw = 1'b1; c.spw = 1'b1; c.spsrc = 2'b10;
    push(5'b00101, 1'b0, 1'b0, 1'b0, c);
    // SPEK@
    push(5'b00100, 1'b1, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b00100, 1'b1, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mdst = 3'b101; push(5'b00100, 1'b1, 1'b1, 1'b0, c);
    c = st_only(3'd4); c.shw = 1'b1; push(5'b00100, 1'b1, 1'b0, 1'b0, c);
    // RPOP
    push(5'b00110, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b00110, 1'b0, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mdst = 3'b100; push(5'b00110, 1'b0, 1'b1, 1'b0, c);
    c = st_only(3'd4); c.raw = 1'b1; c.spw = 1'b1; c.spsrc = 2'b10;
    push(5'b00110, 1'b0, 1'b0, 1'b0, c);
    // BKAC@ with one wait state: SP update only on the ack cycle
    push(5'b10101, 1'b1, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b10101, 1'b1, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mw = 1'b1; c.mdst = 3'b100; c.msrc = 2'b01;
    push(5'b10101, 1'b1, 1'b0, 1'b0, c);
    c.spw = 1'b1; c.spsrc = 2'b01; push(5'b10101, 1'b1, 1'b1, 1'b0, c);
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL misc_ops cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    step_t s; ctl_t a, c; int n = 0;
    push(5'b10011, 1'b0, 1'b1, 1'b0, fetch_exp(1'b1));
    push(5'b10011, 1'b0, 1'b0, 1'b0, st_only(3'd1));
    c = st_only(3'd3); c.req = 1'b1; c.mdst = 3'b001; push(5'b10011, 1'b0, 1'b0, 1'b0, c);
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL mid_mem_pre cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    #2 Reset = 1'b1;
    #1 a = actual(); checks++;
    if (a !== ctl_t'('0)) begin failures++; $display("FAIL mid_mem_async got=%h exp=%h", a, ctl_t'('0)); end
    @(posedge CLK); #1; Reset = 1'b0;
    push(5'b10011, 1'b0, 1'b0, 1'b0, st_only(3'd0));
    push(5'b10011, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0));
    n = 0;
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL mid_mem_post cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  task automatic test_timeout();
    step_t s; ctl_t a, c; int n = 0;
    Reset = 1'b1;
    @(posedge CLK); #1; Reset = 1'b0;
    push(5'b00010, 1'b0, 1'b0, 1'b0, st_only(3'd0));
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) push(5'b00010, 1'b0, 1'b0, 1'b0, fetch_exp(1'b0));
    c = st_only(3'd5); c.halt = 1'b1; c.tmo = 1'b1;
    push(5'b00010, 1'b0, 1'b0, 1'b0, c);
    push(5'b00010, 1'b0, 1'b0, 1'b1, c);
    c = fetch_exp(1'b0); c.tmo = 1'b1;
    push(5'b00010, 1'b0, 1'b0, 1'b0, c);
`else
    c = fetch_exp(1'b0);
    for (int i = 0; i < 100; i++) push(5'b00010, 1'b0, 1'b0, 1'b0, c);
`endif
    while (sq.size() > 0) begin
      s = sq.pop_front(); OPCODE = s.op; flagbit = s.fl; mem_ack = s.ack; resume = s.res;
      @(negedge CLK); a = actual(); checks++;
      if (a !== s.e) begin failures++; $display("FAIL timeout cyc=%0d got=%h exp=%h", n, a, s.e); end
      n++; @(posedge CLK); #1;
    end
    mem_ack = 1'b0; resume = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aadd();
    test_load_wait();
    test_bkra();
    test_illegal_halt();
    test_misc_ops();
    test_reset_mid_mem();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frankie_seq_ctrl.md
Name: frankie_seq_ctrl

Overview:
- Next-generation multicycle control sequencer for the Frankie accumulator/stack CPU.
- Replaces the fixed four-state Fetch/Decode/Third/Fourth cycle with a per-class state machine.
- Memory accesses use a req/ack handshake with arbitrary wait states; the block adds HALT and illegal-opcode detection.
- Drives the same datapath selects (Mary, Shelley, Comp, RA, PC, SP, memory, ALU).

Parameters:
- OPCODE_W, 5, opcode width.
- ALUOP_W, 4, ALU operation width.
- HALT_OP, 5'b11111, opcode that enters HALT.
- TMO_CYCLES, 64, memory-ack timeout; only used with MEM_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- OPCODE  in  OPCODE_W  current instruction-register opcode.
- flagbit  in  1  '@' variant select.
- mem_ack  in  1  memory completes the access this cycle.
- resume  in  1  leave HALT.
- mem_req  out  1  memory access request.
- MemWrite  out  1  write strobe, qualified by mem_req.
- MemDst  out  3  address select.
- MemSrc  out  2  write-data select.
- InstWrite, PCWrite, SPWrite, MaryWrite, ShelleyWrite, CompWrite, RAWrite  out  1 each  register enables.
- PCSrc  out  3  PC select.
- SPSrc, MarySrc, ShelleySrc  out  2 each  selects.
- RASrc, SrcA  out  1 each  selects.
- SrcB  out  2  ALU B-operand select.
- ALUOP  out  ALUOP_W  ALU operation.
- state_o  out  3  current state, for debug.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- tmo_err  out  1  sticky timeout flag; constant 0 when MEM_TIMEOUT_EN is undefined.

Behaviour:
- Reset: state=FETCH. All outputs 0, except mem_req=1 one cycle after Reset deasserts. tmo_err is cleared only by Reset.
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- All control outputs are registered-state decodes (Moore), except InstWrite/PCWrite in FETCH and the MEM-state enables, which are gated by mem_ack.
- Handshake:
  - mem_req is held high in FETCH and MEM until the cycle mem_ack=1.
  - MemDst, MemSrc and MemWrite are stable while mem_req=1.
  - mem_ack while mem_req=0 is ignored.
- FETCH:
  - mem_req=1, MemDst=000.
  - On mem_ack: InstWrite=1, PCWrite=1, PCSrc=000, go to DECODE. Otherwise stay.
  - Minimum fetch is 1 cycle (ack in the same cycle).
- DECODE: all enables 0. Next state by opcode class:
  - ALU (00010 AADD, 00011 ASUB, 01100 CEQU, 01101 CLES, 01110 CGRE, 01111 LORR, 10000 LAND, 10001 SHFL, 10010 SHFR) -> EXEC.
  - Single-cycle (00000 APUT, 00111-01011 jumps, 10111 SWAP) -> EXEC.
  - Memory read (00100 SPEK, 00101 SPOP, 00110 RPOP, 10011 LOAD) -> MEM.
  - Memory write (00001 SPUT, 10100 STOR, 10101 BKAC, 10110 BKRA) -> MEM.
  - HALT_OP -> HALT.
  - Any other opcode: illegal=1, go to FETCH.
- EXEC:
  - ALU class: SrcA=0; SrcB=01 if flagbit=0, else 00. ALUOP: AND 0000, OR 0001, ADD 0010, SUB 0011, LT 0100, GT 0101, EQ 0110, SHL 1000, SHR 1001. Next state WB.
  - Single-cycle class: asserts its enables this cycle, then FETCH.
    - Jumps: JIMM PCSrc 010 (flagbit=0) / 001 (flagbit=1); JACC 100/101; JCMP 110/111; JRET 011; JFNC 010/001 plus RAWrite=1, RASrc=1.
    - APUT: MaryWrite, MarySrc=11 (flagbit=0); ShelleyWrite, ShelleySrc=01 (flagbit=1).
    - SWAP: MaryWrite, MarySrc=10, ShelleyWrite, ShelleySrc=10.
- MEM:
  - mem_req=1.
  - MemDst: 100 for SP ops, 101 for SPEK, 001 for LOAD/STOR, 011 for LOAD@/STOR@.
  - Writes: MemWrite=1. MemSrc 00/01 for BKAC/BKAC@, 10 for BKRA, 00 for SPUT/STOR. On ack: SPWrite=1, SPSrc=01 (push ops only), then FETCH.
  - Reads: on ack go to WB.
- WB:
  - ALU class: MaryWrite=1, MarySrc=01, except the compare ops, which assert CompWrite instead.
  - Read class: MaryWrite (MarySrc=00), or ShelleyWrite (ShelleySrc=00) for SPEK@, or RAWrite/RASrc=0 for RPOP.
  - SPOP and RPOP also assert SPWrite=1, SPSrc=10.
  - Next state FETCH.
- HALT: all enables 0, halted=1. resume=1 -> FETCH.
- OPCODE and flagbit are sampled every cycle; they are held stable by the instruction register between InstWrite pulses.
- Reset mid-MEM: the access is abandoned and mem_req drops asynchronously.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A counter of width $clog2(TMO_CYCLES+1) counts cycles with mem_req=1 and mem_ack=0. It is cleared on state entry.
  - At TMO_CYCLES: set tmo_err, drop mem_req, go to HALT with no enables asserted.
- MEM_TIMEOUT_EN undefined: no counter; the block waits on mem_ack indefinitely; tmo_err is tied to 0.

Decomposition:
- frankie_pkg holds:
  - state encodings;
  - opcode localparams (all names above plus HALT_OP default);
  - ALUOP codes;
  - class enum {CLS_ALU, CLS_ONE, CLS_RD, CLS_WR, CLS_HALT, CLS_ILL}.
- One sub-module, frankie_op_classify: combinational OPCODE -> class plus illegal. The FSM and output decode stay in frankie_seq_ctrl.

Test Plan:
- AADD, mem_ack tied 1: states 0,1,2,4,0. In state 2, ALUOP=0010 and SrcB=01. MaryWrite=1 only in WB. 4 cycles total.
- LOAD@ with mem_ack delayed 3 cycles in MEM: mem_req held 4 cycles with MemDst=011 stable. MaryWrite=1 in the WB cycle only.
- BKRA, ack on the first MEM cycle: MemWrite=1, MemSrc=10, SPWrite=1, SPSrc=01 in the same cycle. Next state FETCH.
- Opcode 11010 -> illegal pulses exactly 1 cycle in DECODE, no enables asserted. Opcode 11111 -> halted=1 until resume=1, then FETCH.
- Reset asserted mid-MEM with mem_req=1: all outputs 0 in the same cycle, no clock edge needed. After release, state=FETCH and mem_req=1.
- MEM_TIMEOUT_EN defined with TMO_CYCLES=4 and mem_ack held 0 in FETCH: tmo_err=1 and halted=1 after 4 cycles. Undefined: mem_req still 1 after 100 cycles.
